// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register busy/countdown entries that stall decode on RAW/WAW hazards.
// Optional macro HAZARD_FWD_EN: results are consumable once forwardable instead of after writeback.
module hazard_scoreboard #(
  parameter int NREGS    = 32,
  parameter int REG_W    = 5,
  parameter int LAT_W    = 3,
  parameter int WB_DELAY = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_rs,
  input  logic [REG_W-1:0]  issue_rt,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic              issue_wen,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic              flush,
  input  logic              advance,
  input  logic              done_valid,
  input  logic [REG_W-1:0]  done_reg,
  output logic              stall,
  output logic [NREGS-1:0]  busy,
  output logic [31:0]       stall_cnt
);

  localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};
  localparam logic [LAT_W-1:0] LAT_SAT = {{(LAT_W-1){1'b1}}, 1'b0};

  logic [NREGS-1:0] r_busy;
  logic [LAT_W-1:0] r_cnt [NREGS];
  logic [31:0]      r_stall_cnt;

  logic [LAT_W-1:0] w_eff_lat;
  logic [LAT_W-1:0] w_done_lat;
  logic             w_raw;
  logic             w_waw;
  logic             w_stall;
  logic             w_accept;
  logic             w_alloc;

`ifdef HAZARD_FWD_EN
  assign w_eff_lat  = issue_lat;
  assign w_done_lat = '0;
`else
  localparam int LAT_MAX_I = (1 << LAT_W) - 1;
  localparam int WB_CLIP   = (WB_DELAY > LAT_MAX_I) ? LAT_MAX_I : WB_DELAY;
  localparam logic [LAT_W-1:0] DONE_LAT =
    (WB_CLIP >= LAT_MAX_I) ? LAT_SAT : LAT_W'(WB_CLIP);

  logic [LAT_W:0] w_lat_sum;
  assign w_lat_sum = {1'b0, issue_lat} + (LAT_W+1)'(WB_CLIP);

  // LAT_MAX stays the variable-latency marker; fixed latencies saturate just below it.
  always_comb begin
    w_eff_lat = w_lat_sum[LAT_W-1:0];
    if (issue_lat == LAT_MAX)
      w_eff_lat = LAT_MAX;
    else if (w_lat_sum >= {1'b0, LAT_MAX})
      w_eff_lat = LAT_SAT;
  end
  assign w_done_lat = DONE_LAT;
`endif

  assign w_raw = ((issue_rs != '0) && r_busy[issue_rs]) ||
                 ((issue_rt != '0) && r_busy[issue_rt]);
  assign w_waw = issue_wen && (issue_rd != '0) && r_busy[issue_rd] &&
                 (r_cnt[issue_rd] > issue_lat);

  assign w_stall  = issue_valid && !flush && (w_raw || w_waw);
  assign w_accept = issue_valid && !flush && !w_stall;
  assign w_alloc  = w_accept && issue_wen && (issue_rd != '0);

  // An entry is busy only while its count is nonzero: it retires on the advance that
  // would take the count to zero, so a latency of N costs a dependent exactly N cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_busy      <= '0;
      r_stall_cnt <= '0;
      for (int r = 0; r < NREGS; r++)
        r_cnt[r] <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      for (int r = 1; r < NREGS; r++) begin
        if (w_alloc && (issue_rd == REG_W'(r))) begin
          r_busy[r] <= (w_eff_lat != '0);
          r_cnt[r]  <= w_eff_lat;
        end else if (r_busy[r]) begin
          if (r_cnt[r] == LAT_MAX) begin
            if (done_valid && (done_reg == REG_W'(r))) begin
              r_busy[r] <= (w_done_lat != '0);
              r_cnt[r]  <= w_done_lat;
            end
          end else if (advance) begin
            if (r_cnt[r] <= LAT_W'(1)) begin
              r_busy[r] <= 1'b0;
              r_cnt[r]  <= '0;
            end else begin
              r_cnt[r] <= r_cnt[r] - LAT_W'(1);
            end
          end
        end
      end
    end
  end

  assign stall     = w_stall;
  assign busy      = r_busy;
  assign stall_cnt = r_stall_cnt;

endmodule
